// File: rtl/compare_seeker_pkg.sv
// Shared definitions for the Logic Machine comparator slice: FSM state
// encoding, comparator op select and the flag-priority resolver.
package logic_machine_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_VERIFY = 3'd3,
        ST_DONE   = 3'd4
    } seek_state_t;

    localparam logic [1:0] OP_EQUAL = 2'b00;

    typedef enum logic [1:0] {
        FLAG_HIT   = 2'd0,
        FLAG_CLEAR = 2'd1,
        FLAG_KEEP  = 2'd2
    } flag_outcome_t;

    // Equal beats less beats greater; any other combination keeps the bit.
    function automatic flag_outcome_t resolve_flags(input logic equal,
                                                    input logic less,
                                                    input logic greater);
        flag_outcome_t outcome;
        if (equal)
            outcome = FLAG_HIT;
        else if (less)
            outcome = FLAG_CLEAR;
        else if (greater)
            outcome = FLAG_KEEP;
        else
            outcome = FLAG_KEEP;
        return outcome;
    endfunction

endpackage

// File: rtl/compare_seeker_settle_counter.sv
// Loadable down-counter with a zero flag. Times how long a trial value is
// held on the comparator before its flags are trusted.
module settle_counter #(
    parameter int CW = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    input  logic          dec,
    output logic          zero
);

    logic [CW-1:0] count;

    // Load wins over decrement; the count parks at zero.
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_value;
        else if (dec && (count != '0))
            count <= count - CW'(1);
    end

    assign zero = (count == '0);

endmodule

// File: rtl/compare_seeker.sv
// Successive-approximation controller for the Logic Machine comparator.
// Drives the comparator's y operand one bit at a time, MSB first, and
// reads back equal/greater/less to recover x.
// Optional feature: define SEEK_VERIFY_EN to add a final verify compare
// that raises error when the found value does not compare equal.
module compare_seeker
    import logic_machine_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             equal,
    input  logic             greater,
    input  logic             less,
    output logic [WIDTH-1:0] guess,
    output logic [1:0]       op,
    output logic [WIDTH-1:0] found,
    output logic [2:0]       steps,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = $clog2(SETTLE + 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB_ONE = ONE << (WIDTH - 1);
    localparam logic [IW-1:0]    TOP_BIT = IW'(WIDTH - 1);

    seek_state_t      state;
    logic [IW-1:0]    bit_idx;
    flag_outcome_t    outcome;
    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] resolved_guess;
    logic [WIDTH-1:0] next_guess;
    logic             cnt_load;
    logic [CW-1:0]    cnt_value;
    logic             cnt_dec;
    logic             settle_zero;

    assign op = OP_EQUAL;

    // Resolve this compare's flags and prepare the following trial value.
    always_comb begin
        outcome        = resolve_flags(equal, less, greater);
        bit_mask       = ONE << bit_idx;
        resolved_guess = (outcome == FLAG_CLEAR) ? (guess & ~bit_mask) : guess;
        next_guess     = resolved_guess | (bit_mask >> 1);
    end

    // Reload the settle counter whenever a new value goes onto the comparator.
    always_comb begin
        cnt_load  = 1'b0;
        cnt_value = CW'(SETTLE - 1);
        cnt_dec   = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: cnt_load = start;
            ST_DRIVE:         cnt_dec  = 1'b1;
            ST_SAMPLE: begin
                if (outcome != FLAG_HIT) begin
                    cnt_load = 1'b1;
`ifdef SEEK_VERIFY_EN
                    if (bit_idx == '0)
                        cnt_value = CW'(SETTLE);
`endif
                end
            end
`ifdef SEEK_VERIFY_EN
            ST_VERIFY:        cnt_dec  = 1'b1;
`endif
            default: ;
        endcase
    end

    settle_counter #(
        .CW(CW)
    ) u_settle (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (cnt_value),
        .dec        (cnt_dec),
        .zero       (settle_zero)
    );

    // Search FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            guess   <= '0;
            found   <= '0;
            steps   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bit_idx <= '0;
`ifdef SEEK_VERIFY_EN
            error   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state   <= ST_DRIVE;
                        guess   <= MSB_ONE;
                        bit_idx <= TOP_BIT;
                        steps   <= '0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
`ifdef SEEK_VERIFY_EN
                        error   <= 1'b0;
`endif
                    end
                end
                ST_DRIVE: begin
                    if (settle_zero)
                        state <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    steps <= steps + 3'd1;
                    if (outcome == FLAG_HIT) begin
                        found <= guess;
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (bit_idx == '0) begin
                        guess <= resolved_guess;
                        found <= resolved_guess;
`ifdef SEEK_VERIFY_EN
                        state <= ST_VERIFY;
`else
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
`endif
                    end else begin
                        guess   <= next_guess;
                        bit_idx <= bit_idx - IW'(1);
                        state   <= ST_DRIVE;
                    end
                end
`ifdef SEEK_VERIFY_EN
                ST_VERIFY: begin
                    if (settle_zero) begin
                        steps <= steps + 3'd1;
                        error <= ~equal;
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifndef SEEK_VERIFY_EN
    assign error = 1'b0;
`endif

endmodule
